mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch (IF) port and the data-memory (DM, MEM-stage) port of the 5-stage pipeline.
Grants one access at a time and sequences a fixed-latency memory access through a small FSM with a wait counter.
Returns read data with a one-cycle ack pulse and drives stall signals that freeze the pipeline stages.
Sits between the Datapath_Unit memory interfaces and the physical memory.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the IF and DM ports.
// DM has priority, but a streak limit makes sure a waiting IF request is eventually granted.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned WAIT_CYCLES   = 2,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [3:0] WaitCnt   = 4'(WAIT_CYCLES);
    localparam logic [3:0] MaxStreak = 4'(MAX_DM_STREAK);
    localparam logic       OwnerIf   = 1'b0;
    localparam logic       OwnerDm   = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StAck  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        streak_q, streak_d;
    logic              owner_q, owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic grant_dm;
    logic grant_if;

    // DM is the older instruction, so it wins unless it has starved a waiting IF long enough.
    assign grant_dm = dm_req && (!if_req || (streak_q < MaxStreak));
    assign grant_if = !grant_dm && if_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (!if_req) begin
                    streak_d = '0;
                end
                if (grant_dm) begin
                    state_d     = StBusy;
                    cnt_d       = WaitCnt;
                    owner_d     = OwnerDm;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (if_req && (streak_q != 4'hF)) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant_if) begin
                    state_d     = StBusy;
                    cnt_d       = WaitCnt;
                    owner_d     = OwnerIf;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = StAck;
                    cnt_d    = '0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q == OwnerDm) begin
                        dm_ack_d = 1'b1;
                        // Stores leave the load-data register untouched.
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            streak_q    <= '0;
            owner_q     <= OwnerIf;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked against a
// transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;

    localparam int W    = 2;
    localparam int MAXS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    logic        rd_mode;
    logic [31:0] rd_fixed;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .WAIT_CYCLES  (W),
        .MAX_DM_STREAK(MAXS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata = rd_mode ? rd_fixed : memf(mem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, if_ack, dm_ack, stall_if, stall_mem} !== 6'b0) begin
            errors++;
            $display("FAIL reset.ctrl got %b exp 000000",
                     {mem_en, mem_we, if_ack, dm_ack, stall_if, stall_mem});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset.mem got %h/%h exp 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if ({if_rdata, dm_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset.rdata got %h/%h exp 0/0", if_rdata, dm_rdata);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_if();
        rd_mode  = 1'b1;
        rd_fixed = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h100;
            end
            if (c == 4) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_en !== (c == 1 || c == 2)) begin
                errors++;
                $display("FAIL single_if.mem_en c=%0d got %b exp %b", c, mem_en, (c == 1 || c == 2));
            end
            checks++;
            if (if_ack !== (c == 3)) begin
                errors++;
                $display("FAIL single_if.if_ack c=%0d got %b exp %b", c, if_ack, (c == 3));
            end
            checks++;
            if (stall_if !== (c <= 2)) begin
                errors++;
                $display("FAIL single_if.stall_if c=%0d got %b exp %b", c, stall_if, (c <= 2));
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL single_if.addr got %h we %b exp 100 we 0", mem_addr, mem_we);
                end
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL single_if.rdata got %h exp deadbeef", if_rdata);
                end
            end
            step();
        end
        rd_mode = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h104;
                dm_req  = 1'b1;
                dm_we   = 1'b0;
                dm_addr = 32'h200;
            end
            if (c == 4) dm_req = 1'b0;
            if (c == 8) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_en !== (c == 1 || c == 2 || c == 5 || c == 6)) begin
                errors++;
                $display("FAIL simul.mem_en c=%0d got %b", c, mem_en);
            end
            checks++;
            if (dm_ack !== (c == 3) || if_ack !== (c == 7)) begin
                errors++;
                $display("FAIL simul.ack c=%0d got dm %b if %b exp dm %b if %b",
                         c, dm_ack, if_ack, (c == 3), (c == 7));
            end
            checks++;
            if (stall_mem !== (c <= 2) || stall_if !== (c <= 6)) begin
                errors++;
                $display("FAIL simul.stall c=%0d got mem %b if %b", c, stall_mem, stall_if);
            end
            if (c == 1 || c == 5) begin
                checks++;
                if (mem_addr !== ((c == 1) ? 32'h200 : 32'h104)) begin
                    errors++;
                    $display("FAIL simul.addr c=%0d got %h", c, mem_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (dm_rdata !== memf(32'h200)) begin
                    errors++;
                    $display("FAIL simul.dm_rdata got %h exp %h", dm_rdata, memf(32'h200));
                end
            end
            if (c == 7) begin
                checks++;
                if (if_rdata !== memf(32'h104)) begin
                    errors++;
                    $display("FAIL simul.if_rdata got %h exp %h", if_rdata, memf(32'h104));
                end
            end
            step();
        end
    endtask

    task automatic test_dm_write();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'b1;
                dm_addr  = 32'h300;
                dm_wdata = 32'h1234_5678;
            end
            if (c == 4) begin
                dm_req = 1'b0;
                dm_we  = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (mem_en !== (c == 1 || c == 2) || mem_we !== (c == 1 || c == 2)) begin
                errors++;
                $display("FAIL write.en_we c=%0d got en %b we %b", c, mem_en, mem_we);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h300) begin
                    errors++;
                    $display("FAIL write.data c=%0d got %h@%h exp 12345678@300", c, mem_wdata, mem_addr);
                end
            end
            checks++;
            if (dm_ack !== (c == 3)) begin
                errors++;
                $display("FAIL write.dm_ack c=%0d got %b exp %b", c, dm_ack, (c == 3));
            end
            checks++;
            if (dm_rdata !== memf(32'h200)) begin
                errors++;
                $display("FAIL write.dm_rdata c=%0d got %h exp %h", c, dm_rdata, memf(32'h200));
            end
            step();
        end
    endtask

    task automatic test_streak();
        int k;
        logic exp_dm;
        for (int c = 0; c < 25; c++) begin
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h500;
                dm_req  = 1'b1;
                dm_we   = 1'b0;
                dm_addr = 32'h400;
            end
            if (c == 24) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            k      = c / 4;
            exp_dm = ((k % (MAXS + 1)) != MAXS);
            @(negedge clk);
            if (c % 4 == 1) begin
                checks++;
                if (mem_en !== 1'b1 || mem_addr !== (exp_dm ? 32'h400 : 32'h500)) begin
                    errors++;
                    $display("FAIL streak.grant k=%0d got en %b addr %h exp dm=%b", k, mem_en, mem_addr, exp_dm);
                end
            end
            if (c % 4 == 0 && c > 0) begin
                checks++;
                if (mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL streak.gap c=%0d got %b exp 0", c, mem_en);
                end
            end
            if (c % 4 == 3) begin
                checks++;
                if (dm_ack !== exp_dm || if_ack !== !exp_dm) begin
                    errors++;
                    $display("FAIL streak.ack k=%0d got dm %b if %b exp dm %b", k, dm_ack, if_ack, exp_dm);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h600;
        step();
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid.busy got %b exp 1", mem_en);
        end
        step();
        rst_n  = 1'b0;
        dm_req = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h0 || dm_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid.abort got en %b addr %h ack %b exp 0 0 0", mem_en, mem_addr, dm_ack);
        end
        step();
        @(negedge clk);
        checks++;
        if (dm_ack !== 1'b0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid.noack got ack %b rd %h/%h exp 0", dm_ack, dm_rdata, if_rdata);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h700;
            end
            if (c == 4) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_en !== (c == 1 || c == 2) || if_ack !== (c == 3)) begin
                errors++;
                $display("FAIL rstmid.fresh c=%0d got en %b ack %b", c, mem_en, if_ack);
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== memf(32'h700)) begin
                    errors++;
                    $display("FAIL rstmid.rdata got %h exp %h", if_rdata, memf(32'h700));
                end
            end
            step();
        end
    endtask

    task automatic test_drop_req();
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin
                dm_req  = 1'b1;
                dm_we   = 1'b0;
                dm_addr = 32'h800;
            end
            if (c == 1) begin
                dm_req  = 1'b0;
                if_req  = 1'b1;
                if_addr = 32'h900;
            end
            if (c == 8) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (dm_ack !== (c == 3) || if_ack !== (c == 7)) begin
                errors++;
                $display("FAIL drop.ack c=%0d got dm %b if %b", c, dm_ack, if_ack);
            end
            checks++;
            if (mem_en !== (c == 1 || c == 2 || c == 5 || c == 6)) begin
                errors++;
                $display("FAIL drop.mem_en c=%0d got %b", c, mem_en);
            end
            if (c >= 1) begin
                checks++;
                if (stall_mem !== 1'b0) begin
                    errors++;
                    $display("FAIL drop.stall_mem c=%0d got %b exp 0", c, stall_mem);
                end
            end
            if (c == 3) begin
                checks++;
                if (dm_rdata !== memf(32'h800)) begin
                    errors++;
                    $display("FAIL drop.dm_rdata got %h exp %h", dm_rdata, memf(32'h800));
                end
            end
            if (c == 5) begin
                checks++;
                if (mem_addr !== 32'h900) begin
                    errors++;
                    $display("FAIL drop.if_addr got %h exp 900", mem_addr);
                end
            end
            if (c == 7) begin
                checks++;
                if (if_rdata !== memf(32'h900)) begin
                    errors++;
                    $display("FAIL drop.if_rdata got %h exp %h", if_rdata, memf(32'h900));
                end
            end
            step();
        end
    endtask

    // Model: each grant at cycle g owns the memory for cycles g+1..g+W, acks at g+W+1,
    // and the arbiter can decide again at g+W+2.
    task automatic test_random();
        localparam int N = 600;
        int          g         = -100;
        int          next_free = 0;
        int          streak    = 0;
        logic        g_dm      = 1'b0;
        logic        g_we      = 1'b0;
        logic [31:0] g_addr    = '0;
        logic [31:0] g_wd      = '0;
        logic [31:0] exp_if_rd = '0;
        logic [31:0] exp_dm_rd = '0;
        logic        if_done   = 1'b0;
        logic        dm_done   = 1'b0;
        logic        in_win, e_if_ack, e_dm_ack;

        if_req = 1'b0;
        dm_req = 1'b0;
        rst_n  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int c = 0; c < N; c++) begin
            if (if_req && if_done) begin
                if ($urandom_range(1) == 0) if_req = 1'b0;
            end else if (!if_req && c < N - 12 && $urandom_range(2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (dm_req && dm_done) begin
                if ($urandom_range(1) == 0) dm_req = 1'b0;
            end else if (!dm_req && c < N - 12 && $urandom_range(2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(1));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            @(negedge clk);
            in_win   = (c >= g + 1) && (c <= g + W);
            e_if_ack = (c == g + W + 1) && !g_dm;
            e_dm_ack = (c == g + W + 1) && g_dm;
            if (e_if_ack) exp_if_rd = memf(g_addr);
            if (e_dm_ack && !g_we) exp_dm_rd = memf(g_addr);
            checks++;
            if (mem_en !== in_win) begin
                errors++;
                $display("FAIL rand.mem_en c=%0d got %b exp %b", c, mem_en, in_win);
            end
            if (in_win) begin
                checks++;
                if (mem_addr !== g_addr || mem_we !== g_we || mem_wdata !== g_wd) begin
                    errors++;
                    $display("FAIL rand.mem c=%0d got %h/%b/%h exp %h/%b/%h",
                             c, mem_addr, mem_we, mem_wdata, g_addr, g_we, g_wd);
                end
            end
            checks++;
            if (if_ack !== e_if_ack || dm_ack !== e_dm_ack) begin
                errors++;
                $display("FAIL rand.ack c=%0d got if %b dm %b exp if %b dm %b",
                         c, if_ack, dm_ack, e_if_ack, e_dm_ack);
            end
            checks++;
            if (if_rdata !== exp_if_rd || dm_rdata !== exp_dm_rd) begin
                errors++;
                $display("FAIL rand.rdata c=%0d got %h/%h exp %h/%h",
                         c, if_rdata, dm_rdata, exp_if_rd, exp_dm_rd);
            end
            checks++;
            if (stall_if !== (if_req && !e_if_ack) || stall_mem !== (dm_req && !e_dm_ack)) begin
                errors++;
                $display("FAIL rand.stall c=%0d got if %b mem %b", c, stall_if, stall_mem);
            end
            if_done = e_if_ack;
            dm_done = e_dm_ack;
            if (c >= next_free) begin
                if (!if_req) streak = 0;
                if (dm_req && (!if_req || streak < MAXS)) begin
                    g         = c;
                    g_dm      = 1'b1;
                    g_addr    = dm_addr;
                    g_we      = dm_we;
                    g_wd      = dm_wdata;
                    next_free = c + W + 2;
                    if (if_req) streak++;
                end else if (if_req) begin
                    g         = c;
                    g_dm      = 1'b0;
                    g_addr    = if_addr;
                    g_we      = 1'b0;
                    g_wd      = '0;
                    next_free = c + W + 2;
                    streak    = 0;
                end
            end
            step();
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        rd_mode  = 1'b0;
        rd_fixed = '0;
        test_reset();
        test_single_if();
        test_simultaneous();
        test_dm_write();
        test_streak();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
